// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter state encoding and the default character width.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_e;

  localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          found,
  output logic [PW-1:0] idx
);

  int cand;

  // Scan from the farthest offset down so the nearest candidate is the last one written.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      if (req[cand[PW-1:0]]) begin
        found = 1'b1;
        idx   = cand[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ byte producers.
// Optional frame lock (req_last holds the grant until end of frame): UART_TX_ARB_LOCK_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = UART_DATA_BITS
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         tx_send_request,
  output logic [DATA_BITS-1:0]         tx_data,
  input  logic                         tx_busy,
  input  logic                         tx_done,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         arb_busy
);

  localparam int PW = $clog2(NUM_REQ);
  localparam logic [PW-1:0] LAST_ID = PW'(NUM_REQ - 1);

  arb_state_e          state_reg, state_next;
  logic [PW-1:0]       rr_ptr_reg, rr_ptr_next;
  logic [PW-1:0]       grant_id_reg, grant_id_next;
  logic [DATA_BITS-1:0] tx_data_reg, tx_data_next;
  logic                send_reg, send_next;
  logic                arb_busy_reg, arb_busy_next;

  logic [NUM_REQ-1:0]  eligible;
  logic                pick_found;
  logic [PW-1:0]       pick_idx;
  logic [PW-1:0]       ptr_after;
  logic [DATA_BITS-1:0] req_bytes [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
      assign req_bytes[gi] = req_data[gi*DATA_BITS +: DATA_BITS];
    end
  endgenerate

`ifdef UART_TX_ARB_LOCK_EN
  logic lock_reg, lock_next;

  // While a frame is open only its owner (the last winner) may be picked.
  always_comb begin
    eligible = req_valid;
    if (lock_reg) eligible = req_valid & (NUM_REQ'(1) << grant_id_reg);
  end
`else
  logic unused_last;
  assign unused_last = ^req_last;
  assign eligible    = req_valid;
`endif

  rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
    .req   (eligible),
    .ptr   (rr_ptr_reg),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign ptr_after = (pick_idx == LAST_ID) ? '0 : pick_idx + 1'b1;

  always_comb begin
    state_next    = state_reg;
    rr_ptr_next   = rr_ptr_reg;
    grant_id_next = grant_id_reg;
    tx_data_next  = tx_data_reg;
    send_next     = send_reg;
    arb_busy_next = arb_busy_reg;
    req_ready     = '0;
`ifdef UART_TX_ARB_LOCK_EN
    lock_next     = lock_reg;
`endif
    case (state_reg)
      IDLE: begin
        // tx_busy/tx_done are ignored here so a lingering tx_done cannot end the next byte.
        if (pick_found && !reset) begin
          req_ready[pick_idx] = 1'b1;
          tx_data_next        = req_bytes[pick_idx];
          grant_id_next       = pick_idx;
          send_next           = 1'b1;
          arb_busy_next       = 1'b1;
          state_next          = ISSUE;
`ifdef UART_TX_ARB_LOCK_EN
          if (req_last[pick_idx]) begin
            rr_ptr_next = ptr_after;
            lock_next   = 1'b0;
          end else begin
            lock_next   = 1'b1;
          end
`else
          rr_ptr_next = ptr_after;
`endif
        end
      end
      ISSUE: begin
        if (tx_busy) begin
          send_next  = 1'b0;
          state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (tx_done) begin
          arb_busy_next = 1'b0;
          state_next    = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      rr_ptr_reg   <= '0;
      grant_id_reg <= '0;
      tx_data_reg  <= '0;
      send_reg     <= 1'b0;
      arb_busy_reg <= 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
      lock_reg     <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      rr_ptr_reg   <= rr_ptr_next;
      grant_id_reg <= grant_id_next;
      tx_data_reg  <= tx_data_next;
      send_reg     <= send_next;
      arb_busy_reg <= arb_busy_next;
`ifdef UART_TX_ARB_LOCK_EN
      lock_reg     <= lock_next;
`endif
    end
  end

  assign tx_send_request = send_reg;
  assign tx_data         = tx_data_reg;
  assign grant_id        = grant_id_reg;
  assign arb_busy        = arb_busy_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter; uart_tx is replaced by hand-driven tx_busy/tx_done.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        tx_send_request;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        tx_done;
  logic [1:0]  grant_id;
  logic        arb_busy;

  int checks = 0;
  int failures = 0;

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_BITS(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_last        (req_last),
    .req_ready       (req_ready),
    .tx_send_request (tx_send_request),
    .tx_data         (tx_data),
    .tx_busy         (tx_busy),
    .tx_done         (tx_done),
    .grant_id        (grant_id),
    .arb_busy        (arb_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] v;
    logic       busy;
    logic       done;
    logic [3:0] rdy;
    logic       send;
    logic [1:0] gid;
    logic       ab;
    logic [7:0] data;
  } vec_t;

  localparam logic [31:0] DATA_DEFAULT = 32'h3CA5_2110;  // r3=3C r2=A5 r1=21 r0=10
  vec_t tbl [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_send(input string name, output logic [7:0] d, output logic [1:0] g);
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_send_request === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk({name, "_send_seen"}, 32'(seen), 32'd1);
    d = tx_data;
    g = grant_id;
  endtask

  task automatic finish_char();
    @(posedge clk); #1 tx_busy = 1'b1;
    @(posedge clk); #1 tx_busy = 1'b0; tx_done = 1'b1;
    @(posedge clk); #1 tx_done = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    logic [1:0] g;
    logic [7:0] exp_bytes [3];
    logic [7:0] dflt;

    tbl[0]  = '{4'b0100, 1'b0, 1'b0, 4'b0100, 1'b0, 2'd0, 1'b0, 8'h00};
    tbl[1]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b1, 8'hA5};
    tbl[2]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b1, 8'hA5};
    tbl[3]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b1, 8'hA5};
    tbl[4]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b1, 8'hA5};
    tbl[5]  = '{4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b1, 8'hA5};
    tbl[6]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b0, 8'hA5};
    tbl[7]  = '{4'b1111, 1'b0, 1'b0, 4'b1000, 1'b0, 2'd2, 1'b0, 8'hA5};
    tbl[8]  = '{4'b1111, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd3, 1'b1, 8'h3C};
    tbl[9]  = '{4'b1111, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b1, 8'h3C};
    tbl[10] = '{4'b1111, 1'b0, 1'b0, 4'b0001, 1'b0, 2'd3, 1'b0, 8'h3C};
    tbl[11] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b1, 8'h10};
    tbl[12] = '{4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1, 8'h10};
    tbl[13] = '{4'b0010, 1'b0, 1'b1, 4'b0010, 1'b0, 2'd0, 1'b0, 8'h10};
    tbl[14] = '{4'b0000, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd1, 1'b1, 8'h21};
    tbl[15] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b1, 8'h21};
    tbl[16] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b1, 8'h21};
    tbl[17] = '{4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b1, 8'h21};
    tbl[18] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b0, 8'h21};

    reset = 1'b1; req_valid = 4'b1111; req_data = DATA_DEFAULT; req_last = 4'b1111;
    tx_busy = 1'b0; tx_done = 1'b0;

    // Reset state, with every requester asking.
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_send", 32'(tx_send_request), 32'h0);
    chk("rst_data", 32'(tx_data), 32'h0);
    chk("rst_gid", 32'(grant_id), 32'h0);
    chk("rst_busy", 32'(arb_busy), 32'h0);
    @(posedge clk); #1 reset = 1'b0; req_valid = 4'b0000;

    // Table: single requester, busy/done tracking, stale tx_done in IDLE.
    for (int i = 0; i < 19; i++) begin
      req_valid = tbl[i].v; tx_busy = tbl[i].busy; tx_done = tbl[i].done;
      @(negedge clk);
      chk($sformatf("row%0d_ready", i), 32'(req_ready), 32'(tbl[i].rdy));
      chk($sformatf("row%0d_send", i), 32'(tx_send_request), 32'(tbl[i].send));
      chk($sformatf("row%0d_gid", i), 32'(grant_id), 32'(tbl[i].gid));
      chk($sformatf("row%0d_busy", i), 32'(arb_busy), 32'(tbl[i].ab));
      chk($sformatf("row%0d_data", i), 32'(tx_data), 32'(tbl[i].data));
      @(posedge clk); #1;
    end
    req_valid = 4'b0000; tx_busy = 1'b0; tx_done = 1'b0;

    // All four continuously valid from rr_ptr=0: order 0,1,2,3,0.
    do_reset();
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_send($sformatf("rr%0d", k), d, g);
      dflt = DATA_DEFAULT[(k % 4)*8 +: 8];
      chk($sformatf("rr%0d_gid", k), 32'(g), 32'(k % 4));
      chk($sformatf("rr%0d_data", k), 32'(d), 32'(dflt));
      finish_char();
    end
    req_valid = 4'b0000;

    // Reset asserted in WAIT_DONE, then a fresh search from rr_ptr=0.
    do_reset();
    req_valid = 4'b0100;
    wait_send("mid", d, g);
    @(posedge clk); #1 tx_busy = 1'b1;
    @(posedge clk); #1 tx_busy = 1'b0;
    @(negedge clk);
    chk("mid_in_wait", 32'(arb_busy), 32'h1);
    @(posedge clk); #1 reset = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(req_ready), 32'h0);
    chk("mid_rst_send", 32'(tx_send_request), 32'h0);
    chk("mid_rst_data", 32'(tx_data), 32'h0);
    chk("mid_rst_gid", 32'(grant_id), 32'h0);
    chk("mid_rst_busy", 32'(arb_busy), 32'h0);
    @(posedge clk); #1 reset = 1'b0; req_valid = 4'b0010;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 32'b0010);
    @(posedge clk); #1;
    chk("post_rst_gid", 32'(grant_id), 32'd1);
    chk("post_rst_send", 32'(tx_send_request), 32'd1);
    req_valid = 4'b0000;
    finish_char();

    // Frame: req 0 sends 0x11 (last=0) then 0x22 (last=1) while req 1 offers 0x55.
    do_reset();
`ifdef UART_TX_ARB_LOCK_EN
    exp_bytes[0] = 8'h11; exp_bytes[1] = 8'h22; exp_bytes[2] = 8'h55;
`else
    exp_bytes[0] = 8'h11; exp_bytes[1] = 8'h55; exp_bytes[2] = 8'h22;
`endif
    req_data = 32'h0000_5511; req_last = 4'b1110; req_valid = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      wait_send($sformatf("frame%0d", k), d, g);
      chk($sformatf("frame%0d_data", k), 32'(d), 32'(exp_bytes[k]));
      if (d == 8'h11) begin
        req_data[7:0] = 8'h22;
        req_last[0]   = 1'b1;
      end else if (d == 8'h22) begin
        req_valid[0] = 1'b0;
      end else begin
        req_valid[1] = 1'b0;
      end
      finish_char();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one `uart_tx` transmitter among `NUM_REQ` byte producers. Each producer offers bytes on a valid/ready interface. The arbiter picks a winner, latches its byte, drives `send_request`/`tx_data` into `uart_tx`, and tracks `tx_busy`/`tx_done` until the character has fully left the pin. It sits between the UART client logic (console, debug, status streams) and `uart_tx`. `parity_enable` and `baud_tick` wiring stay outside this block.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (≥2)
- `DATA_BITS`, 8, byte width; must match `uart_tx`

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high
- `req_valid`  in  NUM_REQ  requester i has a byte
- `req_data`  in  NUM_REQ*DATA_BITS  byte of requester i at `[i*DATA_BITS +: DATA_BITS]`
- `req_last`  in  NUM_REQ  byte is last of a frame (used only with lock feature)
- `req_ready`  out  NUM_REQ  one-hot accept; transfer when valid&ready at clk edge
- `tx_send_request`  out  1  to `uart_tx.send_request`
- `tx_data`  out  DATA_BITS  to `uart_tx.tx_data`
- `tx_busy`  in  1  from `uart_tx.tx_busy`
- `tx_done`  in  1  from `uart_tx.tx_done`
- `grant_id`  out  $clog2(NUM_REQ)  index of current/last winner
- `arb_busy`  out  1  high from byte accept until its `tx_done` is seen

## Operation
- States: IDLE, ISSUE, WAIT_DONE.
- **IDLE**
  - If any eligible `req_valid`, the winner is the first set bit searching upward from `rr_ptr`, wrapping modulo NUM_REQ.
  - `req_ready[winner]`=1 combinationally in that cycle; all other bits 0.
  - At the edge: `tx_data`←winner's byte, `grant_id`←winner, `rr_ptr`←(winner+1) mod NUM_REQ, `tx_send_request`←1, `arb_busy`←1, go to ISSUE.
- **ISSUE**
  - Hold `tx_send_request`=1 and `tx_data` stable until `tx_busy`=1 is sampled. `uart_tx` only samples on `baud_tick`, so this may take up to one baud period.
  - On `tx_busy`=1: `tx_send_request`←0, go to WAIT_DONE.
- **WAIT_DONE**
  - On `tx_done`=1: `arb_busy`←0, go to IDLE.
  - `tx_done` stays high for one baud period. IDLE must not treat the stale `tx_done` as completion of the next byte: only a `tx_done` seen in WAIT_DONE counts.
- `req_ready` is 0 in ISSUE and WAIT_DONE, and while `reset` is high.
- `req_valid` may drop without a handshake; no byte is accepted in that case.
- Requester data must be stable only in the accept cycle.
- `tx_done`/`tx_busy` seen in IDLE is ignored.
- Width rules:
  - `rr_ptr` wraps by explicit compare to NUM_REQ-1, since NUM_REQ need not be a power of 2.
  - `grant_id` is $clog2(NUM_REQ) bits.

## Timing
- Reset values: state IDLE, `rr_ptr`=0, `grant_id`=0, `tx_data`=0, `tx_send_request`=0, `arb_busy`=0, `req_ready`=0, lock cleared.
- Accept-to-`tx_send_request` latency: 1 clk.
- Back-to-back: the next accept can occur on the clk after `tx_done` is seen in WAIT_DONE (IDLE entered). Minimum gap between characters is the `uart_tx` DONE→IDLE baud period.
- Reset mid-operation:
  - All state returns to reset values; the latched byte is dropped.
  - The arbiter does not replay the byte.
  - `uart_tx` shares `reset`.
- Simultaneous requests: exactly one `req_ready` bit per accept; fairness bound is NUM_REQ-1 characters of waiting.

## Configuration
- Macro: `UART_TX_ARB_LOCK_EN`.
- **Defined (frame lock):**
  - After accepting a byte with `req_last`=0, the winner is locked. Only that requester is eligible in IDLE until a byte with `req_last`=1 from it is accepted.
  - `rr_ptr` advances only when the lock is released.
  - A locked requester with `req_valid`=0 stalls the arbiter by design.
- **Undefined:** `req_last` is ignored and arbitration happens per byte.

## Structure
- Shared `uart_pkg`: `arb_state_e` enum (IDLE, ISSUE, WAIT_DONE) and the `UART_DATA_BITS` default constant.
- One sub-module, `rr_pick`: combinational, inputs are the request vector and `rr_ptr`; outputs are the `found` flag and the winner index.

## Test plan
- **Single requester:** req 2 sends 0xA5 → `req_ready[2]` pulses 1 clk; `tx_send_request` held until `tx_busy`; `grant_id`=2; line carries 0xA5 LSB-first; `arb_busy` falls after `tx_done`.
- **All four valid continuously, `rr_ptr`=0:** grant order 0,1,2,3,0; each byte sent exactly once.
- **Stale done:** `tx_done` high while in IDLE with a new request → arbiter waits for `tx_busy` and then a fresh `tx_done`; no early return to IDLE.
- **Reset asserted in WAIT_DONE:** all outputs return to reset values the same cycle; after release, req 1 → first grant is 1 (`rr_ptr`=0 search).
- **Lock enabled:** req 0 frame 0x11 (last=0), 0x22 (last=1) with req 1 valid → order 0x11, 0x22, then req 1.
- **Lock disabled, same stimulus:** order 0x11, req 1's byte, 0x22.
